// File: rtl/irq_controller_pkg.sv
// Shared FSM encoding and register offsets for the interrupt controller.
package irq_controller_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAssert  = 2'd1,
        StService = 2'd2
    } irq_state_e;

    localparam logic [7:0] OffMask   = 8'd0;
    localparam logic [7:0] OffPend   = 8'd1;
    localparam logic [7:0] OffCause  = 8'd2;
    localparam logic [7:0] OffEoiOvr = 8'd3;
    localparam logic [7:0] OffOvrClr = 8'd4;
    localparam logic [7:0] NumPorts  = 8'd5;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
module irq_prio_enc #(
    parameter int unsigned NSRC = 4
) (
    input  logic [NSRC-1:0] req,
    output logic [2:0]      idx,
    output logic            any
);

    always_comb begin
        idx = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (req[i]) idx = 3'(i);
        end
    end

    assign any = |req;

endmodule

// File: rtl/irq_controller.sv
// Edge-triggered interrupt controller with mask/pending/cause/overrun registers
// on a processor port bus, and a request/acknowledge/EOI handshake FSM.
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int unsigned NSRC      = 4,
    parameter logic [7:0]  BASE_PORT = 8'h10
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NSRC-1:0] src,
    input  logic [7:0]      port_id,
    input  logic [7:0]      out_port,
    input  logic            write_strobe,
    output logic [7:0]      rd_data,
    output logic            rd_hit,
    output logic            interrupt,
    input  logic            interrupt_ack
);

    logic [NSRC-1:0] src_q, pending_q, pending_d, mask_q, mask_d;
    logic [NSRC-1:0] rise, active, ack_clr, w1c;
    logic [7:0]      cause_q, cause_d, overrun_q, overrun_d, rd_data_q, rd_data_d;
    logic            rd_hit_q, rd_hit_d, interrupt_q, interrupt_d;
    irq_state_e      state_q, state_d;
    logic [7:0]      offset;
    logic            owned, wr_en, ack_take, eoi_take;
    logic [2:0]      prio_idx;
    logic            prio_any;
    logic            unused_wdata;

    assign rise   = src & ~src_q;
    assign active = pending_q & mask_q;
    assign offset = port_id - BASE_PORT;
    assign owned  = (port_id >= BASE_PORT) && (offset < NumPorts);
    assign wr_en  = write_strobe && owned;
    // Data bits above NSRC are intentionally dropped on writes.
    assign unused_wdata = ^out_port;

    irq_prio_enc #(
        .NSRC(NSRC)
    ) u_prio_enc (
        .req(active),
        .idx(prio_idx),
        .any(prio_any)
    );

    always_comb begin
        state_d  = state_q;
        ack_take = 1'b0;
        eoi_take = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (prio_any) state_d = StAssert;
            end
            StAssert: begin
                if (interrupt_ack && prio_any) begin
                    state_d  = StService;
                    ack_take = 1'b1;
                end else if (!prio_any) begin
                    state_d = StIdle;
                end
            end
            StService: begin
                if (wr_en && offset == OffEoiOvr) begin
                    state_d  = StIdle;
                    eoi_take = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        interrupt_d = (state_d == StAssert);
    end

    always_comb begin
        mask_d    = mask_q;
        w1c       = '0;
        ack_clr   = '0;
        cause_d   = cause_q;
        overrun_d = overrun_q;
        if (wr_en && offset == OffMask) mask_d = out_port[NSRC-1:0];
        if (wr_en && offset == OffPend) w1c = out_port[NSRC-1:0];
        for (int i = 0; i < int'(NSRC); i++) begin
            ack_clr[i] = ack_take && (prio_idx == 3'(i));
        end
        // Rise is OR-ed last so a new event beats any same-cycle clear.
        pending_d = (pending_q & ~(w1c | ack_clr)) | rise;
        if (ack_take) begin
            cause_d = {1'b1, 4'b0, prio_idx};
        end else if (eoi_take) begin
            cause_d[7] = 1'b0;
        end
        if (wr_en && offset == OffOvrClr) begin
            overrun_d = '0;
        end else if (|(rise & pending_q) && overrun_q != 8'hFF) begin
            overrun_d = overrun_q + 8'd1;
        end
    end

    always_comb begin
        rd_hit_d  = owned;
        rd_data_d = '0;
        if (owned) begin
            case (offset)
                OffMask:   rd_data_d = 8'(mask_q);
                OffPend:   rd_data_d = 8'(pending_q);
                OffCause:  rd_data_d = cause_q;
                OffEoiOvr: rd_data_d = overrun_q;
                default:   rd_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            src_q       <= '0;
            pending_q   <= '0;
            mask_q      <= '0;
            cause_q     <= '0;
            overrun_q   <= '0;
            rd_data_q   <= '0;
            rd_hit_q    <= 1'b0;
            interrupt_q <= 1'b0;
            state_q     <= StIdle;
        end else begin
            src_q       <= src;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            cause_q     <= cause_d;
            overrun_q   <= overrun_d;
            rd_data_q   <= rd_data_d;
            rd_hit_q    <= rd_hit_d;
            interrupt_q <= interrupt_d;
            state_q     <= state_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_hit    = rd_hit_q;
    assign interrupt = interrupt_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with hand-computed expected values.
module tb_irq_controller;

    localparam logic [7:0] Base = 8'h10;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] src = 4'h0;
    logic [7:0] port_id = 8'h00;
    logic [7:0] out_port = 8'h00;
    logic       write_strobe = 1'b0;
    logic       interrupt_ack = 1'b0;
    logic [7:0] rd_data;
    logic       rd_hit;
    logic       interrupt;

    int checks = 0;
    int failures = 0;

    irq_controller #(
        .NSRC(4),
        .BASE_PORT(Base)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .src(src),
        .port_id(port_id),
        .out_port(out_port),
        .write_strobe(write_strobe),
        .rd_data(rd_data),
        .rd_hit(rd_hit),
        .interrupt(interrupt),
        .interrupt_ack(interrupt_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        port_id = a;
        out_port = d;
        write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0;
        port_id = 8'h00;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d, output logic h);
        port_id = a;
        tick();
        d = rd_data;
        h = rd_hit;
        port_id = 8'h00;
    endtask

    task automatic pulse(input logic [3:0] m);
        src = src | m;
        tick();
        src = src & ~m;
    endtask

    task automatic ack();
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic h;
        reset_n = 1'b0;
        tick();
        tick();
        if (interrupt !== 1'b0) begin failures++; $display("FAIL rst_irq: got %b want 0", interrupt); end
        checks++;
        if (rd_hit !== 1'b0 || rd_data !== 8'h00) begin
            failures++; $display("FAIL rst_rd: got hit=%b data=%h want 0/00", rd_hit, rd_data);
        end
        checks++;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd(Base + 8'(i), d, h);
            if (d !== 8'h00 || h !== 1'b1) begin
                failures++; $display("FAIL rst_reg%0d: got %h hit=%b want 00 hit=1", i, d, h);
            end
            checks++;
        end
        rd(Base + 8'd5, d, h);
        if (d !== 8'h00 || h !== 1'b0) begin
            failures++; $display("FAIL nonowned_rd: got %h hit=%b want 00 hit=0", d, h);
        end
        checks++;
    endtask

    task automatic test_single_source();
        logic [7:0] d;
        logic h;
        wr(Base, 8'h0F);
        pulse(4'b0100);
        if (interrupt !== 1'b0) begin failures++; $display("FAIL single_early: got %b want 0", interrupt); end
        checks++;
        tick();
        if (interrupt !== 1'b1) begin failures++; $display("FAIL single_irq: got %b want 1", interrupt); end
        checks++;
        ack();
        if (interrupt !== 1'b0) begin failures++; $display("FAIL single_ack_irq: got %b want 0", interrupt); end
        checks++;
        rd(Base + 8'd2, d, h);
        if (d !== 8'h82) begin failures++; $display("FAIL single_cause: got %h want 82", d); end
        checks++;
        rd(Base + 8'd1, d, h);
        if (d !== 8'h00) begin failures++; $display("FAIL single_pend: got %h want 00", d); end
        checks++;
        if (interrupt !== 1'b0) begin failures++; $display("FAIL single_service: got %b want 0", interrupt); end
        checks++;
        wr(Base + 8'd3, 8'h00);
        rd(Base + 8'd2, d, h);
        if (d !== 8'h02) begin failures++; $display("FAIL single_eoi_cause: got %h want 02", d); end
        checks++;
    endtask

    task automatic test_two_sources();
        logic [7:0] d;
        logic h;
        pulse(4'b1010);
        tick();
        if (interrupt !== 1'b1) begin failures++; $display("FAIL two_irq: got %b want 1", interrupt); end
        checks++;
        ack();
        rd(Base + 8'd2, d, h);
        if (d !== 8'h81) begin failures++; $display("FAIL two_cause1: got %h want 81", d); end
        checks++;
        rd(Base + 8'd1, d, h);
        if (d !== 8'h08) begin failures++; $display("FAIL two_pend: got %h want 08", d); end
        checks++;
        wr(Base + 8'd3, 8'h00);
        if (interrupt !== 1'b0) begin failures++; $display("FAIL two_eoi_irq: got %b want 0", interrupt); end
        checks++;
        tick();
        if (interrupt !== 1'b1) begin failures++; $display("FAIL two_reassert: got %b want 1", interrupt); end
        checks++;
        ack();
        rd(Base + 8'd2, d, h);
        if (d !== 8'h83) begin failures++; $display("FAIL two_cause2: got %h want 83", d); end
        checks++;
        wr(Base + 8'd3, 8'h00);
        tick();
        if (interrupt !== 1'b0) begin failures++; $display("FAIL two_idle: got %b want 0", interrupt); end
        checks++;
    endtask

    task automatic test_mask_gate();
        logic [7:0] d;
        logic h;
        wr(Base, 8'h00);
        pulse(4'b0001);
        tick();
        tick();
        if (interrupt !== 1'b0) begin failures++; $display("FAIL mask_blocked: got %b want 0", interrupt); end
        checks++;
        rd(Base + 8'd1, d, h);
        if (d !== 8'h01) begin failures++; $display("FAIL mask_pend: got %h want 01", d); end
        checks++;
        wr(Base, 8'h01);
        tick();
        if (interrupt !== 1'b1) begin failures++; $display("FAIL mask_open: got %b want 1", interrupt); end
        checks++;
        wr(Base + 8'd1, 8'h01);
        tick();
        if (interrupt !== 1'b0) begin failures++; $display("FAIL mask_withdraw: got %b want 0", interrupt); end
        checks++;
        ack();
        if (interrupt !== 1'b0) begin failures++; $display("FAIL late_ack_irq: got %b want 0", interrupt); end
        checks++;
        rd(Base + 8'd2, d, h);
        if (d !== 8'h03) begin failures++; $display("FAIL late_ack_cause: got %h want 03", d); end
        checks++;
    endtask

    task automatic test_eoi_with_event();
        logic [7:0] d;
        logic h;
        wr(Base, 8'h0F);
        pulse(4'b0001);
        tick();
        ack();
        port_id = Base + 8'd3;
        out_port = 8'h00;
        write_strobe = 1'b1;
        src = 4'b0100;
        tick();
        write_strobe = 1'b0;
        src = 4'b0000;
        port_id = 8'h00;
        if (interrupt !== 1'b0) begin failures++; $display("FAIL eoi_ev_irq0: got %b want 0", interrupt); end
        checks++;
        rd(Base + 8'd1, d, h);
        if (d !== 8'h04) begin failures++; $display("FAIL eoi_ev_pend: got %h want 04", d); end
        checks++;
        if (interrupt !== 1'b1) begin failures++; $display("FAIL eoi_ev_rereq: got %b want 1", interrupt); end
        checks++;
        ack();
        rd(Base + 8'd2, d, h);
        if (d !== 8'h82) begin failures++; $display("FAIL eoi_ev_cause: got %h want 82", d); end
        checks++;
        wr(Base + 8'd3, 8'h00);
        tick();
    endtask

    task automatic test_overrun_and_map();
        logic [7:0] d;
        logic h;
        wr(Base, 8'hFF);
        rd(Base, d, h);
        if (d !== 8'h0F) begin failures++; $display("FAIL mask_width: got %h want 0F", d); end
        checks++;
        wr(Base + 8'd5, 8'h00);
        wr(Base - 8'd1, 8'h00);
        rd(Base, d, h);
        if (d !== 8'h0F) begin failures++; $display("FAIL nonowned_wr: got %h want 0F", d); end
        checks++;
        wr(Base, 8'h00);
        rd(Base + 8'd3, d, h);
        if (d !== 8'h00) begin failures++; $display("FAIL ovr_start: got %h want 00", d); end
        checks++;
        for (int i = 0; i < 10; i++) begin
            pulse(4'b0010);
            tick();
        end
        rd(Base + 8'd3, d, h);
        if (d !== 8'h09) begin failures++; $display("FAIL ovr_count: got %h want 09", d); end
        checks++;
        for (int i = 0; i < 290; i++) begin
            pulse(4'b0010);
            tick();
        end
        rd(Base + 8'd3, d, h);
        if (d !== 8'hFF) begin failures++; $display("FAIL ovr_sat: got %h want FF", d); end
        checks++;
        wr(Base + 8'd4, 8'h55);
        rd(Base + 8'd3, d, h);
        if (d !== 8'h00) begin failures++; $display("FAIL ovr_clr: got %h want 00", d); end
        checks++;
        wr(Base + 8'd1, 8'hFF);
        rd(Base + 8'd1, d, h);
        if (d !== 8'h00) begin failures++; $display("FAIL pend_w1c: got %h want 00", d); end
        checks++;
    endtask

    task automatic test_reset_mid_service();
        logic [7:0] d;
        logic h;
        wr(Base, 8'h0F);
        pulse(4'b0001);
        tick();
        ack();
        rd(Base + 8'd2, d, h);
        if (d !== 8'h80) begin failures++; $display("FAIL rst_mid_cause: got %h want 80", d); end
        checks++;
        src = 4'b1000;
        reset_n = 1'b0;
        tick();
        if (interrupt !== 1'b0 || rd_hit !== 1'b0 || rd_data !== 8'h00) begin
            failures++;
            $display("FAIL rst_mid_out: got irq=%b hit=%b data=%h want 0/0/00", interrupt, rd_hit, rd_data);
        end
        checks++;
        reset_n = 1'b1;
        tick();
        rd(Base + 8'd1, d, h);
        if (d !== 8'h08) begin failures++; $display("FAIL rst_rise_pend: got %h want 08", d); end
        checks++;
        rd(Base, d, h);
        if (d !== 8'h00) begin failures++; $display("FAIL rst_mid_mask: got %h want 00", d); end
        checks++;
        rd(Base + 8'd2, d, h);
        if (d !== 8'h00) begin failures++; $display("FAIL rst_mid_cause0: got %h want 00", d); end
        checks++;
        tick();
        tick();
        rd(Base + 8'd3, d, h);
        if (d !== 8'h00) begin failures++; $display("FAIL rst_held_ovr: got %h want 00", d); end
        checks++;
        wr(Base, 8'h08);
        tick();
        if (interrupt !== 1'b1) begin failures++; $display("FAIL rst_idle_req: got %b want 1", interrupt); end
        checks++;
        src = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_two_sources();
        test_mask_gate();
        test_eoi_with_event();
        test_overrun_and_map();
        test_reset_mid_service();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 The block SHALL have parameter NSRC, default 4, giving the number of interrupt sources (1..8).
REQ-002 The block SHALL have parameter BASE_PORT, default 8'h10, giving the first of five consecutive owned port_id addresses.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 src  input  NSRC  level event sources, e.g. upd_sysregs or a ms tick; bit 0 has highest priority.
REQ-006 port_id  input  8  processor port address.
REQ-007 out_port  input  8  processor write data.
REQ-008 write_strobe  input  1  one-cycle write qualifier.
REQ-009 rd_data  output  8  registered read data for owned ports.
REQ-010 rd_hit  output  1  registered flag: rd_data valid because the previous port_id was owned.
REQ-011 interrupt  output  1  interrupt request to the processor.
REQ-012 interrupt_ack  input  1  one-cycle processor acknowledge.

Function
REQ-013 Edge detect SHALL register src into src_q each cycle; rise[i] = src[i] & ~src_q[i].
REQ-014 pending[i] SHALL set on rise[i], clear on W1C write to BASE+1, and clear for the granted index on interrupt_ack; a set SHALL win over a same-cycle clear.
REQ-015 A rise on an already-set pending bit SHALL increment an 8-bit overrun counter, saturating at 255, +1 per cycle regardless of how many bits overrun.
REQ-016 Register map: BASE+0 mask RW; BASE+1 pending R/W1C; BASE+2 cause R; BASE+3 overrun R, EOI on write; BASE+4 overrun clear on write (data ignored).
REQ-017 Writes SHALL take effect on the cycle after write_strobe with matching port_id; non-owned writes SHALL be ignored.
REQ-018 Reads SHALL be unqualified: rd_data/rd_hit SHALL reflect port_id of the previous cycle (latency 1); rd_data SHALL be 0 with rd_hit=0 for non-owned ports.
REQ-019 active = pending & mask; bits at index >= NSRC SHALL read 0 and ignore writes.
REQ-020 FSM states IDLE, ASSERT, SERVICE.
REQ-021 IDLE: if |active, next state ASSERT and interrupt=1 from the next cycle.
REQ-022 ASSERT: interrupt SHALL stay 1 until interrupt_ack; on ack, cause = {1'b1, 4'b0, lowest set index of active}, that pending bit cleared, interrupt=0 next cycle, go SERVICE.
REQ-023 ASSERT: if active becomes 0 before ack (masked or cleared), interrupt SHALL drop next cycle and FSM return to IDLE; a later ack SHALL be ignored.
REQ-024 SERVICE: interrupt SHALL stay 0; new events SHALL latch into pending; an EOI write SHALL clear cause[7] and go IDLE.
REQ-025 interrupt_ack in IDLE or SERVICE SHALL have no effect.
REQ-026 Simultaneous EOI write and new event SHALL both take effect; IDLE re-requests on the following cycle.

Reset
REQ-027 While reset_n=0 at a clk edge: src_q, pending, mask, cause, overrun, rd_data, rd_hit, interrupt SHALL be 0 and FSM SHALL be IDLE; reset mid-ASSERT/SERVICE SHALL abandon the cycle.
REQ-028 A source high at reset release SHALL register one rise on the first post-reset cycle.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding and port offsets (MASK=0, PEND=1, CAUSE=2, EOI_OVR=3, OVR_CLR=4).
REQ-030 The priority encoder SHALL be one sub-module, irq_prio_enc (NSRC-bit in, 3-bit index and any-valid out).

Verification
REQ-031 mask=8'h0F, pulse src[2] -> interrupt=1 two cycles later; ack -> cause=8'h82, pending[2]=0, interrupt=0; EOI -> cause=8'h02, IDLE.
REQ-032 mask=8'h0F, src[3] and src[1] rise same cycle -> ack cause=8'h81; EOI -> interrupt re-asserts; second ack cause=8'h83.
REQ-033 mask=0, pulse src[0] -> interrupt stays 0, pending reads 8'h01; write mask 8'h01 -> interrupt rises; write PEND 8'h01 before ack -> interrupt drops, FSM IDLE.
REQ-034 Pulse src[1] 300 times with no service -> overrun reads 255; write BASE+4 -> overrun reads 0.
REQ-035 reset_n=0 one cycle during SERVICE -> all registers 0, interrupt 0, IDLE; held-high src re-raises pending once.
